// File: rtl/fuzz_vector_sequencer.sv
`default_nettype none
// ==========================================================================
// Module : fuzz_vector_sequencer
// Desc   : LFSR stimulus sequencer with 32-bit MISR response compaction.
//          Optional per-vector capture port under FUZZ_SEQ_CAPTURE_EN.
// Rev    : 1.0
// ==========================================================================
module fuzz_vector_sequencer #(
    parameter int          IN_W    = 72,
    parameter int          OUT_W   = 336,
    parameter int          NUM_VEC = 20,
    parameter int          DUT_LAT = 1,
    parameter logic [63:0] SEED    = 64'h67583e813d7b5521
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [63:0]      seed,
    input  logic [OUT_W-1:0] dut_y,
    output logic [IN_W-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_count,
    output logic [31:0]      signature
`ifdef FUZZ_SEQ_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [OUT_W-1:0] cap_data
`endif
);

    localparam logic [2:0]  c_IDLE        = 3'd0;
    localparam logic [2:0]  c_APPLY       = 3'd1;
    localparam logic [2:0]  c_SETTLE      = 3'd2;
    localparam logic [2:0]  c_CAPTURE     = 3'd3;
    localparam logic [2:0]  c_DONE        = 3'd4;
    localparam logic [2:0]  c_AFTER_APPLY = (DUT_LAT > 0) ? c_SETTLE : c_CAPTURE;
    localparam logic [3:0]  c_LAT_LAST    = 4'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    localparam logic [16:0] c_NUM_VEC     = 17'(NUM_VEC);
    localparam int          c_NSL         = (OUT_W + 31) / 32;
    localparam logic [63:0] c_TAPS        = 64'hD800_0000_0000_0000;
    localparam logic [31:0] c_POLY        = 32'h04C1_1DB7;

    logic [2:0]          r_state, w_next;
    logic [63:0]         r_lfsr, r_seed, w_lfsr_step, w_lfsr_nxt, w_seed_nxt;
    logic [3:0]          r_lat, w_lat_nxt;
    logic [c_NSL*32-1:0] w_y_pad;
    logic [31:0]         w_fold, w_sig_step, w_sig_nxt;
    logic [IN_W-1:0]     w_stim_vec, w_stim_nxt;
    logic [15:0]         w_cnt_nxt;
    logic                w_active, w_abort, w_last, w_busy_nxt, w_done_nxt;
`ifdef FUZZ_SEQ_CAPTURE_EN
    logic                w_cap_valid_nxt;
    logic [OUT_W-1:0]    w_cap_data_nxt;
`endif

    assign w_active    = (r_state == c_APPLY) || (r_state == c_SETTLE) || (r_state == c_CAPTURE);
    assign w_abort     = abort && w_active;
    assign w_last      = (({1'b0, vec_count} + 17'd1) == c_NUM_VEC);
    assign w_lfsr_step = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? c_TAPS : 64'd0);
    assign w_sig_step  = {signature[30:0], 1'b0} ^ (signature[31] ? c_POLY : 32'd0) ^ w_fold;

    // Next vector is the low IN_W bits of {lfsr, ~lfsr} after stepping.
    always_comb begin
        w_stim_vec = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_stim_vec[i] = (i < 64) ? ~w_lfsr_step[i % 64] : w_lfsr_step[i % 64];
        end
    end

    always_comb begin
        w_y_pad              = '0;
        w_y_pad[OUT_W-1:0]   = dut_y;
        w_fold               = '0;
        for (int i = 0; i < c_NSL; i++) begin
            w_fold = w_fold ^ w_y_pad[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (start) w_next = c_APPLY;
            c_APPLY:        w_next = w_abort ? c_IDLE : c_AFTER_APPLY;
            c_SETTLE: begin
                if (w_abort)                   w_next = c_IDLE;
                else if (r_lat == c_LAT_LAST)  w_next = c_CAPTURE;
            end
            c_CAPTURE: begin
                if (w_abort)     w_next = c_IDLE;
                else if (w_last) w_next = c_DONE;
                else             w_next = c_APPLY;
            end
            default:        w_next = c_IDLE;
        endcase
    end

    // busy/done are registered views of the state, one cycle behind it.
    always_comb begin
        w_stim_nxt = stim;
        w_lfsr_nxt = r_lfsr;
        w_sig_nxt  = signature;
        w_cnt_nxt  = vec_count;
        w_lat_nxt  = '0;
        w_seed_nxt = r_seed;
        w_busy_nxt = w_active && !w_abort;
        w_done_nxt = (r_state == c_DONE) && !start;
`ifdef FUZZ_SEQ_CAPTURE_EN
        w_cap_valid_nxt = 1'b0;
        w_cap_data_nxt  = cap_data;
`endif
        if (seed_load && !w_active) w_seed_nxt = (seed == 64'd0) ? SEED : seed;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_stim_nxt = '0;
                    w_lfsr_nxt = r_seed;
                    w_cnt_nxt  = '0;
                    w_sig_nxt  = 32'hFFFF_FFFF;
                end
            end
            c_SETTLE:  w_lat_nxt = r_lat + 4'd1;
            c_CAPTURE: begin
                if (!w_abort) begin
                    w_sig_nxt = w_sig_step;
                    w_cnt_nxt = vec_count + 16'd1;
`ifdef FUZZ_SEQ_CAPTURE_EN
                    w_cap_valid_nxt = 1'b1;
                    w_cap_data_nxt  = dut_y;
`endif
                    if (!w_last) begin
                        w_lfsr_nxt = w_lfsr_step;
                        w_stim_nxt = w_stim_vec;
                    end
                end
            end
            default: ;
        endcase
        if (w_abort) w_stim_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_count <= '0;
            signature <= '0;
            r_seed    <= SEED;
            r_lfsr    <= SEED;
            r_lat     <= '0;
`ifdef FUZZ_SEQ_CAPTURE_EN
            cap_valid <= 1'b0;
            cap_data  <= '0;
`endif
        end else begin
            stim      <= w_stim_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            vec_count <= w_cnt_nxt;
            signature <= w_sig_nxt;
            r_seed    <= w_seed_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_lat     <= w_lat_nxt;
`ifdef FUZZ_SEQ_CAPTURE_EN
            cap_valid <= w_cap_valid_nxt;
            cap_data  <= w_cap_data_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
